// File: rtl/hnf_mshr_hazard_wakeup_pkg.sv
// Shared sizing, wakeup-state encodings and a lowest-bit-first encoder for the
// HN-F MSHR sleep/wakeup tracker.
package hnf_mshr_hazard_wakeup_pkg;

    localparam int MSHR_ENTRIES_NUM   = 16;
    localparam int MSHR_ENTRIES_WIDTH = 4;

    typedef enum logic [1:0] {
        HNF_WAKE_IDLE  = 2'd0,
        HNF_WAKE_SLEEP = 2'd1,
        HNF_WAKE_PEND  = 2'd2
    } wake_state_e;

    // Lowest set bit wins, so a malformed multi-hot vector still yields one index.
    function automatic logic [MSHR_ENTRIES_WIDTH-1:0] penc(input logic [MSHR_ENTRIES_NUM-1:0] v);
        logic [MSHR_ENTRIES_WIDTH-1:0] idx;
        idx = '0;
        for (int i = MSHR_ENTRIES_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = MSHR_ENTRIES_WIDTH'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hnf_mshr_hazard_wakeup_rr_arb.sv
// N-way round-robin arbiter: search starts at i_ptr and wraps; purely combinational.
// Returns a one-hot grant, the encoded winner (0 when idle) and an any-request flag.
module hnf_rr_arb #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_vld
);

    logic [W-1:0] w_pos;
    logic         w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = W'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
        o_vld = w_found;
    end

endmodule

// File: rtl/hnf_mshr_hazard_wakeup.sv
// Tracks which MSHR entry each hazarded entry sleeps on and hands woken entries
// to the MSHR control one per cycle; wakeup is visible the cycle after the retire.
module hnf_mshr_hazard_wakeup
    import hnf_mshr_hazard_wakeup_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mshr_alloc_en_s1_q,
    input  logic [MSHR_ENTRIES_WIDTH-1:0] mshr_entry_idx_alloc_s1_q,
    input  logic                          rxreq_cam_hazard_s1_q,
    input  logic [MSHR_ENTRIES_NUM-1:0]   rxreq_cam_hazard_entry_s1_q,
    input  logic                          mshr_l3_hazard_valid_sx3_q,
    input  logic [MSHR_ENTRIES_NUM-1:0]   pipe_cam_hazard_entry_sx3_q,
    input  logic [MSHR_ENTRIES_NUM-1:0]   pipe_sleep_entry_sx3_q,
    input  logic                          mshr_dbf_retired_valid_sx1_q,
    input  logic [MSHR_ENTRIES_WIDTH-1:0] mshr_dbf_retired_idx_sx1_q,
    input  logic                          mshr_wakeup_ready_sx1,
    output logic                          mshr_wakeup_valid_sx1,
    output logic [MSHR_ENTRIES_WIDTH-1:0] mshr_wakeup_idx_sx1,
    output logic [MSHR_ENTRIES_NUM-1:0]   mshr_sleep_entry_q
);

    localparam int N = MSHR_ENTRIES_NUM;
    localparam int W = MSHR_ENTRIES_WIDTH;

    wake_state_e  r_state [N];
    logic [W-1:0] r_blk   [N];
    logic [W-1:0] r_rr;

    wake_state_e  w_state_nxt [N];
    logic [W-1:0] w_blk_nxt   [N];
    logic [W-1:0] w_rr_nxt;

    logic [W-1:0] w_s1_blk;
    logic [W-1:0] w_sx3_blk;
    logic [W-1:0] w_sx3_tgt;
    logic         w_s1_reg;
    logic         w_sx3_reg;
    logic         w_s1_byp;
    logic         w_sx3_byp;
    logic [N-1:0] w_s1_hit;
    logic [N-1:0] w_sx3_hit;
    logic [N-1:0] w_ret_self;
    logic [N-1:0] w_pend_req;
    logic [N-1:0] w_wake_gnt;
    logic [W-1:0] w_wake_idx;
    logic         w_wake_vld;
    logic         w_hs;

    assign w_s1_blk  = penc(rxreq_cam_hazard_entry_s1_q);
    assign w_sx3_blk = penc(pipe_cam_hazard_entry_sx3_q);
    assign w_sx3_tgt = penc(pipe_sleep_entry_sx3_q);
    assign w_s1_reg  = mshr_alloc_en_s1_q && rxreq_cam_hazard_s1_q;
    assign w_sx3_reg = mshr_l3_hazard_valid_sx3_q;
    // A blocker retiring in the registration cycle would otherwise be missed forever.
    assign w_s1_byp  = mshr_dbf_retired_valid_sx1_q && (w_s1_blk == mshr_dbf_retired_idx_sx1_q);
    assign w_sx3_byp = mshr_dbf_retired_valid_sx1_q && (w_sx3_blk == mshr_dbf_retired_idx_sx1_q);
    assign w_hs      = w_wake_vld && mshr_wakeup_ready_sx1;

    always_comb begin
        w_s1_hit   = '0;
        w_sx3_hit  = '0;
        w_ret_self = '0;
        for (int i = 0; i < N; i++) begin
            w_s1_hit[i]   = w_s1_reg && (mshr_entry_idx_alloc_s1_q == W'(i));
            w_sx3_hit[i]  = w_sx3_reg && (w_sx3_tgt == W'(i));
            w_ret_self[i] = mshr_dbf_retired_valid_sx1_q && (mshr_dbf_retired_idx_sx1_q == W'(i));
        end
    end

    hnf_rr_arb #(
        .N (N),
        .W (W)
    ) u_wake_arb (
        .i_req (w_pend_req),
        .i_ptr (r_rr),
        .o_gnt (w_wake_gnt),
        .o_idx (w_wake_idx),
        .o_vld (w_wake_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= HNF_WAKE_IDLE;
                r_blk[i]   <= '0;
            end
            r_rr <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_blk[i]   <= w_blk_nxt[i];
            end
            r_rr <= w_rr_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_state_nxt[i] = r_state[i];
            w_blk_nxt[i]   = r_blk[i];
            if (w_ret_self[i]) begin
                w_state_nxt[i] = HNF_WAKE_IDLE;
            end else if (w_s1_hit[i] || w_sx3_hit[i]) begin
                // sx3 wins a same-target collision with s1.
                if (w_sx3_hit[i]) begin
                    w_blk_nxt[i]   = w_sx3_blk;
                    w_state_nxt[i] = w_sx3_byp ? HNF_WAKE_PEND : HNF_WAKE_SLEEP;
                end else begin
                    w_blk_nxt[i]   = w_s1_blk;
                    w_state_nxt[i] = w_s1_byp ? HNF_WAKE_PEND : HNF_WAKE_SLEEP;
                end
            end else if (w_hs && w_wake_gnt[i]) begin
                w_state_nxt[i] = HNF_WAKE_IDLE;
            end else if ((r_state[i] == HNF_WAKE_SLEEP) && mshr_dbf_retired_valid_sx1_q &&
                         (r_blk[i] == mshr_dbf_retired_idx_sx1_q)) begin
                w_state_nxt[i] = HNF_WAKE_PEND;
            end
        end
        // While stalled the pointer parks on the winner so a newly pending entry cannot preempt it.
        w_rr_nxt = r_rr;
        if (w_wake_vld) begin
            w_rr_nxt = mshr_wakeup_ready_sx1 ? (w_wake_idx + W'(1)) : w_wake_idx;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_pend_req[i]         = (r_state[i] == HNF_WAKE_PEND);
            mshr_sleep_entry_q[i] = (r_state[i] != HNF_WAKE_IDLE);
        end
        mshr_wakeup_valid_sx1 = w_wake_vld;
        mshr_wakeup_idx_sx1   = w_wake_idx;
    end

`ifndef SYNTHESIS
    // DISPLAY_FATAL checks for producer protocol violations.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_s1_reg && w_sx3_reg && (mshr_entry_idx_alloc_s1_q == w_sx3_tgt)))
                else $error("hnf_mshr_hazard_wakeup: s1 and sx3 sleep the same entry %0d", w_sx3_tgt);
            assert (!(w_s1_reg && (w_s1_blk == mshr_entry_idx_alloc_s1_q)))
                else $error("hnf_mshr_hazard_wakeup: s1 entry %0d blocked on itself", w_s1_blk);
            assert (!(w_sx3_reg && (w_sx3_blk == w_sx3_tgt)))
                else $error("hnf_mshr_hazard_wakeup: sx3 entry %0d blocked on itself", w_sx3_blk);
        end
    end
`endif

endmodule

// File: tb/tb_hnf_mshr_hazard_wakeup.sv
// Directed bench for hnf_mshr_hazard_wakeup: inputs change 1ns after the rising
// edge, outputs are checked at that same point against hand-computed values.
module tb_hnf_mshr_hazard_wakeup;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_en;
    logic [3:0]  alloc_idx;
    logic        s1_haz;
    logic [15:0] s1_haz_ent;
    logic        sx3_vld;
    logic [15:0] sx3_cam;
    logic [15:0] sx3_sleep;
    logic        ret_vld;
    logic [3:0]  ret_idx;
    logic        ready;
    logic        wk_vld;
    logic [3:0]  wk_idx;
    logic [15:0] sleep_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hnf_mshr_hazard_wakeup dut (
        .clk                          (clk),
        .rst                          (rst),
        .mshr_alloc_en_s1_q           (alloc_en),
        .mshr_entry_idx_alloc_s1_q    (alloc_idx),
        .rxreq_cam_hazard_s1_q        (s1_haz),
        .rxreq_cam_hazard_entry_s1_q  (s1_haz_ent),
        .mshr_l3_hazard_valid_sx3_q   (sx3_vld),
        .pipe_cam_hazard_entry_sx3_q  (sx3_cam),
        .pipe_sleep_entry_sx3_q       (sx3_sleep),
        .mshr_dbf_retired_valid_sx1_q (ret_vld),
        .mshr_dbf_retired_idx_sx1_q   (ret_idx),
        .mshr_wakeup_ready_sx1        (ready),
        .mshr_wakeup_valid_sx1        (wk_vld),
        .mshr_wakeup_idx_sx1          (wk_idx),
        .mshr_sleep_entry_q           (sleep_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        alloc_en   = 1'b0;
        alloc_idx  = '0;
        s1_haz     = 1'b0;
        s1_haz_ent = '0;
        sx3_vld    = 1'b0;
        sx3_cam    = '0;
        sx3_sleep  = '0;
        ret_vld    = 1'b0;
        ret_idx    = '0;
    endtask

    task automatic s1_sleep(input int ent, input int blk);
        alloc_en   = 1'b1;
        alloc_idx  = 4'(ent);
        s1_haz     = 1'b1;
        s1_haz_ent = 16'(1) << blk;
    endtask

    task automatic sx3_sleep_on(input int ent, input int blk);
        sx3_vld   = 1'b1;
        sx3_sleep = 16'(1) << ent;
        sx3_cam   = 16'(1) << blk;
    endtask

    task automatic retire(input int ent);
        ret_vld = 1'b1;
        ret_idx = 4'(ent);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] i, input logic [15:0] s);
        chk({tag, ".valid"}, 32'(wk_vld), 32'(v));
        chk({tag, ".idx"},   32'(wk_idx), 32'(i));
        chk({tag, ".sleep"}, 32'(sleep_q), 32'(s));
    endtask

    initial begin
        quiet();
        ready = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_out("reset", 1'b0, 4'd0, 16'h0000);

        // Basic: entry 3 sleeps on 5, 5 retires four cycles later
        s1_sleep(3, 5);
        tick();
        quiet();
        chk_out("basic.sleep", 1'b0, 4'd0, 16'h0008);
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("basic.wait", 1'b0, 4'd0, 16'h0008);
        end
        retire(5);
        tick();
        quiet();
        chk_out("basic.wake", 1'b1, 4'd3, 16'h0008);
        tick();
        chk_out("basic.done", 1'b0, 4'd0, 16'h0000);

        // Multiple waiters on entry 0 from a clean pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s1_sleep(1, 0);
        tick();
        quiet();
        s1_sleep(7, 0);
        sx3_sleep_on(12, 0);
        tick();
        quiet();
        chk_out("multi.sleep", 1'b0, 4'd0, 16'h1082);
        retire(0);
        tick();
        quiet();
        chk_out("multi.w1", 1'b1, 4'd1, 16'h1082);
        tick();
        chk_out("multi.w7", 1'b1, 4'd7, 16'h1080);
        tick();
        chk_out("multi.w12", 1'b1, 4'd12, 16'h1000);
        tick();
        chk_out("multi.done", 1'b0, 4'd0, 16'h0000);

        // Pointer 13 -> wake 13 -> pointer 14
        s1_sleep(13, 11);
        tick();
        quiet();
        retire(11);
        tick();
        quiet();
        chk_out("rr13.wake", 1'b1, 4'd13, 16'h2000);
        tick();
        chk_out("rr13.done", 1'b0, 4'd0, 16'h0000);

        // Wrap and backpressure: pointer 14, pending {15,2}
        ready = 1'b0;
        s1_sleep(15, 9);
        sx3_sleep_on(2, 9);
        tick();
        quiet();
        chk_out("wrap.sleep", 1'b0, 4'd0, 16'h8004);
        retire(9);
        tick();
        quiet();
        chk_out("wrap.stall0", 1'b1, 4'd15, 16'h8004);
        tick();
        chk_out("wrap.stall1", 1'b1, 4'd15, 16'h8004);
        tick();
        chk_out("wrap.stall2", 1'b1, 4'd15, 16'h8004);
        ready = 1'b1;
        tick();
        chk_out("wrap.w2", 1'b1, 4'd2, 16'h0004);
        tick();
        chk_out("wrap.done", 1'b0, 4'd0, 16'h0000);

        // Registration while an unrelated entry retires stays asleep
        ready = 1'b0;
        sx3_sleep_on(4, 9);
        retire(8);
        tick();
        quiet();
        chk_out("nobyp.sleep", 1'b0, 4'd0, 16'h0010);
        retire(9);
        tick();
        quiet();
        chk_out("nobyp.wake", 1'b1, 4'd4, 16'h0010);
        ready = 1'b1;
        tick();
        chk_out("nobyp.done", 1'b0, 4'd0, 16'h0000);

        // Bypass: sx3 sleeps 4 on 9 in the cycle 9 retires
        ready = 1'b0;
        sx3_sleep_on(4, 9);
        retire(9);
        tick();
        quiet();
        chk_out("bypass.wake", 1'b1, 4'd4, 16'h0010);
        ready = 1'b1;
        tick();
        chk_out("bypass.done", 1'b0, 4'd0, 16'h0000);

        // Simultaneous sources: s1 2->6, sx3 8->10
        s1_sleep(2, 6);
        sx3_sleep_on(8, 10);
        tick();
        quiet();
        chk_out("simul.sleep", 1'b0, 4'd0, 16'h0104);
        retire(10);
        tick();
        quiet();
        chk_out("simul.w8", 1'b1, 4'd8, 16'h0104);
        tick();
        chk_out("simul.mid", 1'b0, 4'd0, 16'h0004);
        retire(6);
        tick();
        quiet();
        chk_out("simul.w2", 1'b1, 4'd2, 16'h0004);
        tick();
        chk_out("simul.done", 1'b0, 4'd0, 16'h0000);

        // Retire of the stalled winner drops it; then reset with 3 pending
        ready = 1'b0;
        s1_sleep(5, 3);
        sx3_sleep_on(6, 3);
        tick();
        quiet();
        s1_sleep(10, 3);
        tick();
        quiet();
        retire(3);
        tick();
        quiet();
        chk_out("kill.pend", 1'b1, 4'd5, 16'h0460);
        retire(5);
        tick();
        quiet();
        chk_out("kill.drop", 1'b1, 4'd6, 16'h0440);
        s1_sleep(12, 0);
        tick();
        quiet();
        retire(0);
        tick();
        quiet();
        chk_out("rst.pre", 1'b1, 4'd6, 16'h1440);
        rst = 1'b1;
        tick();
        chk_out("rst.edge", 1'b0, 4'd0, 16'h0000);
        rst   = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out("rst.after", 1'b0, 4'd0, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
